// File: rtl/erasure_locator_buffer.sv
// Erasure-locator generator and buffer: steps a GF(2^SYM_W) locator through one
// codeword, stores the locators of flagged symbols and serves them by index afterwards.
module erasure_locator_buffer #(
    parameter int          SYM_W     = 8,
    parameter int unsigned PRIM_POLY = 285,
    parameter int          N_SYM     = 255,
    parameter int unsigned INIT_LOC  = 142,
    parameter int          MAX_ERAS  = 32,
    parameter int          ADDR_W    = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_erase_reg,
    input  logic              new_data,
    input  logic              erase_flag,
    input  logic              send_erasure_positions,
    input  logic [ADDR_W-1:0] erasure_addr,
    output logic [SYM_W-1:0]  erase_position,
    output logic              loc_valid,
    output logic [SYM_W-1:0]  erasure_data,
    output logic              erasure_ready,
    output logic [ADDR_W:0]   erasure_count,
    output logic              erasure_overflow,
    output logic              codeword_done,
    output logic              busy
);

    localparam logic [SYM_W:0]   POLY     = PRIM_POLY[SYM_W:0];
    localparam logic [SYM_W-1:0] INIT     = INIT_LOC[SYM_W-1:0];
    localparam int               CNT_W    = $clog2(N_SYM + 1);
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(N_SYM - 1);
    localparam logic [ADDR_W:0]  FULL     = (ADDR_W + 1)'(MAX_ERAS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SYM_W-1:0]  loc;
    logic [CNT_W-1:0]  sym_cnt;
    logic [SYM_W-1:0]  mem [MAX_ERAS];
    logic              accept;
    logic              last_sym;
    logic              count_full;
    logic              store;
    logic              read_req;
    logic              addr_hit;

    // Multiply by alpha^-1: fold the polynomial in when the lsb is set, then shift down.
    function automatic logic [SYM_W-1:0] step_down(input logic [SYM_W-1:0] v);
        logic [SYM_W:0] t;
        t = {1'b0, v};
        if (v[0]) begin
            t = t ^ POLY;
        end
        return t[SYM_W:1];
    endfunction

    assign accept     = (state_q == COLLECT) && new_data && !init_erase_reg;
    assign last_sym   = (sym_cnt == LAST_SYM);
    assign count_full = (erasure_count == FULL);
    assign store      = accept && erase_flag && !count_full;
    assign read_req   = (state_q == DONE) && send_erasure_positions && !init_erase_reg;
    assign addr_hit   = ({1'b0, erasure_addr} < erasure_count);
    assign busy       = (state_q == COLLECT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (init_erase_reg) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                COLLECT: if (new_data && last_sym) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            loc              <= INIT;
            sym_cnt          <= '0;
            erasure_count    <= '0;
            erasure_overflow <= 1'b0;
            erase_position   <= '0;
            loc_valid        <= 1'b0;
            codeword_done    <= 1'b0;
            erasure_ready    <= 1'b0;
            erasure_data     <= '0;
        end else begin
            loc_valid     <= 1'b0;
            codeword_done <= 1'b0;
            erasure_ready <= 1'b0;
            erasure_data  <= '0;
            if (init_erase_reg) begin
                loc              <= INIT;
                sym_cnt          <= '0;
                erasure_count    <= '0;
                erasure_overflow <= 1'b0;
                erase_position   <= '0;
            end else if (accept) begin
                loc_valid      <= 1'b1;
                erase_position <= erase_flag ? loc : '0;
                loc            <= step_down(loc);
                sym_cnt        <= sym_cnt + 1'b1;
                codeword_done  <= last_sym;
                if (erase_flag) begin
                    if (count_full) begin
                        erasure_overflow <= 1'b1;
                    end else begin
                        erasure_count <= erasure_count + 1'b1;
                    end
                end
            end else if (read_req) begin
                erasure_ready <= 1'b1;
                erasure_data  <= addr_hit ? mem[erasure_addr] : '0;
            end
        end
    end

    // Storage is left unreset; stale entries stay invisible because reads are gated by the count.
    always_ff @(posedge clock) begin
        if (reset && store) begin
            mem[erasure_count[ADDR_W-1:0]] <= loc;
        end
    end

endmodule
